alu_result_bcd_seq: RTL
=======================

Name: alu_result_bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the 5-bit ALU stage.
- Consumes the 10-bit unsigned ALU result and produces four packed BCD digits plus a leading-zero blank mask.
- Uses iterative shift-and-add-3 (double dabble), one bit per clock.
- Output feeds the per-digit 7-segment decoders (HEX0..HEX3).

Parameters:
- WIDTH, 10, width of binary input (unsigned).
- DIGITS, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- bin_in  input  WIDTH  unsigned ALU result to convert.
- start  input  1  conversion request; sampled only in IDLE.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/blank are updated.
- bcd_out  output  4*DIGITS  packed BCD; digit k in bits [4k+3:4k], digit 0 = units.
- blank  output  DIGITS  1 = digit is a leading zero and should be blanked; bit 0 always 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: when rst=1 at a clock edge, FSM goes to IDLE, busy=0, done=0, bcd_out=0, blank={DIGITS-1{1},0}, shift/scratch/counter cleared. This applies in any state, including mid-conversion.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1 at an edge: latch bin_in into the binary shift register, clear the BCD scratch, load bit counter = WIDTH, go to SHIFT.
  - Otherwise hold. bcd_out and blank keep their last values.
- SHIFT, each cycle:
  - For every scratch digit >= 5, add 3 (all digits adjusted in parallel on the pre-shift value).
  - Then shift {scratch, binreg} left by 1.
  - Decrement counter. When the counter reaches 0 after this shift, go to FINISH.
  - Exactly WIDTH shift cycles are performed.
- FINISH (1 cycle): at the exit edge, bcd_out <= scratch, blank computed, done <= 1 for exactly the following cycle; return to IDLE.
- busy = 1 in SHIFT and FINISH, 0 in IDLE. busy is registered/state-decoded, never combinational from start.
- Latency: start sampled at edge E0 -> done high in cycle after edge E0+WIDTH+1 (11 edges for WIDTH=10). A new start can be accepted in the same cycle done is high (IDLE).
- start while busy: ignored, not queued. The conversion in progress is unaffected.
- bin_in changes during conversion: no effect; only the value at the accepting edge is used.
- blank: digit k (k>=1) is blanked iff it and all higher digits are 0. Value 0 gives blank = all ones except bit 0.
- Arithmetic: scratch digits never exceed 9 after adjust+shift. Results are exact for 0..2^WIDTH-1; no overflow flag needed with the defaults.

Test Plan:
- Reset, then start with bin_in=0 -> after 11 edges done pulses 1 cycle; bcd_out=16'h0000, blank=4'b1110, busy falls with done.
- bin_in=1023 (max) -> bcd_out=16'h1023, blank=4'b0000; done exactly 1 cycle wide.
- bin_in=509 then bin_in=7 back-to-back (second start in the done cycle) -> 16'h0509/blank 4'b1000, then 16'h0007/blank 4'b1110; no idle gap required.
- Start 300, pulse start with bin_in=999 at cycle 4 and change bin_in every cycle -> result 16'h0300; no second done without a new start in IDLE.
- Start 888, assert rst at cycle 5 for one edge -> busy=0, bcd_out=0, blank=4'b1110, no done; a later start 42 -> 16'h0042, blank 4'b1100.
- Exhaustive sweep 0..1023 with a reference model -> every bcd_out/blank matches; latency is always 11 edges.

Source files
------------

// File: rtl/alu_result_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for the ALU result display path.
// Produces packed BCD digits plus a leading-zero blank mask for the HEX digit decoders.
module alu_result_bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t                state_q,   state_d;
    logic [WIDTH-1:0]      bin_q,     bin_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
    logic [DIGITS-1:0]     blank_q,   blank_d;
    logic                  done_q,    done_d;
    logic                  busy_q,    busy_d;

    logic [4*DIGITS-1:0]   adj;
    logic                  zero_run;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        adj       = scratch_q;
        zero_run  = 1'b1;

        // Add-3 correction on every digit in parallel, applied to the pre-shift value.
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
                bin_d     = {bin_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d = scratch_q;
                // A digit blanks only while every digit above it is also zero.
                for (int k = DIGITS - 1; k >= 1; k--) begin
                    zero_run   = zero_run & (scratch_q[4*k +: 4] == 4'd0);
                    blank_d[k] = zero_run;
                end
                blank_d[0] = 1'b0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign blank   = blank_q;

endmodule
